// File: rtl/trc_retire_ctrl.sv
// Trace retire controller: in-order completion queue of trace records.
// Writebacks mark entries complete and patch the rd_value word; complete
// records at the head are serialized one 32-bit word per handshake.
module trc_retire_ctrl #(
    parameter int DEPTH  = 4,
    parameter int NWORDS = 13,
    parameter int RDW    = 8,
    parameter int XLEN   = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     alloc_val,
    output logic                     alloc_rdy,
    input  logic [4:0]               alloc_tag,
    input  logic                     alloc_done,
    input  logic [NWORDS*32-1:0]     alloc_rec,
    input  logic                     wb_val,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_res,
    input  logic                     ewb_val,
    input  logic [4:0]               ewb_rd,
    input  logic [XLEN-1:0]          ewb_res,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_nomatch
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WW-1:0] LAST_IDX = WW'(NWORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   widx_q, widx_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            alloc_rdy_q, alloc_rdy_d;
    logic            out_val_q, out_val_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            err_q, err_d;
    logic [4:0]      tag_q [DEPTH];
    logic [4:0]      tag_d [DEPTH];
    logic            done_q [DEPTH];
    logic            done_d [DEPTH];
    logic [31:0]     rec_q [DEPTH][NWORDS];
    logic [31:0]     rec_d [DEPTH][NWORDS];

    logic            alloc_fire_s;
    logic            pop_s;
    logic [WW-1:0]   widx_nx_s;
    logic            wb_hit_s, ewb_hit_s;
    logic [PW-1:0]   wb_idx_s, ewb_idx_s;
    logic [PW-1:0]   slot_s;
    logic            elig_s, wb_take_s, ewb_take_s;

    assign alloc_rdy   = alloc_rdy_q;
    assign out_val     = out_val_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign count       = count_q;
    assign err_nomatch = err_q;

    assign alloc_fire_s = alloc_val & alloc_rdy_q;
    assign widx_nx_s    = widx_q + WW'(1);

    // Find the oldest incomplete entry per writeback port; ewb skips the wb winner.
    always_comb begin
        wb_hit_s   = 1'b0;
        ewb_hit_s  = 1'b0;
        wb_idx_s   = '0;
        ewb_idx_s  = '0;
        slot_s     = '0;
        elig_s     = 1'b0;
        wb_take_s  = 1'b0;
        ewb_take_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s     = rd_ptr_q + PW'(i);
            elig_s     = (CW'(i) < count_q) && !done_q[slot_s];
            wb_take_s  = wb_val && !wb_hit_s && elig_s && (tag_q[slot_s] == wb_rd);
            ewb_take_s = ewb_val && !ewb_hit_s && elig_s && !wb_take_s
                         && (tag_q[slot_s] == ewb_rd);
            wb_idx_s   = wb_take_s ? slot_s : wb_idx_s;
            ewb_idx_s  = ewb_take_s ? slot_s : ewb_idx_s;
            wb_hit_s   = wb_hit_s | wb_take_s;
            ewb_hit_s  = ewb_hit_s | ewb_take_s;
        end
    end

    // Serializer FSM: start on a complete head, step words on out_rdy, pop after last.
    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && done_q[rd_ptr_q]) begin
                    state_d    = ST_SEND;
                    widx_d     = '0;
                    out_val_d  = 1'b1;
                    out_data_d = rec_q[rd_ptr_q][0];
                    out_last_d = (LAST_IDX == '0);
                end else begin
                    state_d    = ST_IDLE;
                    out_val_d  = 1'b0;
                    out_data_d = 32'd0;
                    out_last_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (out_rdy) begin
                    if (widx_q == LAST_IDX) begin
                        pop_s      = 1'b1;
                        state_d    = ST_IDLE;
                        widx_d     = '0;
                        out_val_d  = 1'b0;
                        out_data_d = 32'd0;
                        out_last_d = 1'b0;
                    end else begin
                        widx_d     = widx_nx_s;
                        out_data_d = rec_q[rd_ptr_q][widx_nx_s];
                        out_last_d = (widx_nx_s == LAST_IDX);
                    end
                end else begin
                    widx_d     = widx_q;
                    out_data_d = out_data_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                widx_d     = '0;
                out_val_d  = 1'b0;
                out_data_d = 32'd0;
                out_last_d = 1'b0;
            end
        endcase
    end

    // Queue bookkeeping: allocation at the tail, writeback patches, head pop, error flag.
    always_comb begin
        rec_d    = rec_q;
        tag_d    = tag_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        if (alloc_fire_s) begin
            for (int k = 0; k < NWORDS; k++) begin
                rec_d[wr_ptr_q][k] = alloc_rec[32*k +: 32];
            end
            tag_d[wr_ptr_q]  = alloc_tag;
            done_d[wr_ptr_q] = alloc_done;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (wb_hit_s) begin
            done_d[wb_idx_s]       = 1'b1;
            rec_d[wb_idx_s][RDW]   = (wb_rd == 5'd0) ? 32'd0 : wb_res;
        end else begin
            done_d[wb_idx_s]       = done_d[wb_idx_s];
        end
        if (ewb_hit_s) begin
            done_d[ewb_idx_s]      = 1'b1;
            rec_d[ewb_idx_s][RDW]  = (ewb_rd == 5'd0) ? 32'd0 : ewb_res;
        end else begin
            done_d[ewb_idx_s]      = done_d[ewb_idx_s];
        end
        rd_ptr_d    = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d     = count_q + CW'(alloc_fire_s) - CW'(pop_s);
        alloc_rdy_d = (count_d < CW'(DEPTH));
        err_d       = err_q | (wb_val & ~wb_hit_s) | (ewb_val & ~ewb_hit_s);
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            alloc_rdy_q <= 1'b1;
            out_val_q   <= 1'b0;
            out_data_q  <= 32'd0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            tag_q       <= '{default: 5'd0};
            done_q      <= '{default: 1'b0};
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            alloc_rdy_q <= alloc_rdy_d;
            out_val_q   <= out_val_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
            done_q      <= done_d;
        end
    end

    // Record storage; contents are only meaningful for occupied entries, so no reset.
    always_ff @(posedge clk) begin
        rec_q <= rec_d;
    end

endmodule

// File: tb/tb_trc_retire_ctrl.sv
// Scoreboard bench for trc_retire_ctrl: expected words are queued at
// allocation; a negedge monitor checks every transferred word.
module tb_trc_retire_ctrl;

    localparam int DEPTH  = 4;
    localparam int NWORDS = 13;
    localparam int RDW    = 8;
    localparam int XLEN   = 32;

    logic                   clk = 1'b0;
    logic                   arst_n;
    logic                   alloc_val;
    logic                   alloc_rdy;
    logic [4:0]             alloc_tag;
    logic                   alloc_done;
    logic [NWORDS*32-1:0]   alloc_rec;
    logic                   wb_val;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_res;
    logic                   ewb_val;
    logic [4:0]             ewb_rd;
    logic [XLEN-1:0]        ewb_res;
    logic                   out_val;
    logic                   out_rdy;
    logic [31:0]            out_data;
    logic                   out_last;
    logic [2:0]             count;
    logic                   err_nomatch;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    trc_retire_ctrl #(.DEPTH(DEPTH), .NWORDS(NWORDS), .RDW(RDW), .XLEN(XLEN)) dut (
        .clk(clk), .arst_n(arst_n),
        .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
        .alloc_done(alloc_done), .alloc_rec(alloc_rec),
        .wb_val(wb_val), .wb_rd(wb_rd), .wb_res(wb_res),
        .ewb_val(ewb_val), .ewb_rd(ewb_rd), .ewb_res(ewb_res),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .count(count), .err_nomatch(err_nomatch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int id, input int k);
        return 32'h1000_0000 + 32'(id) * 32'h0001_0000 + 32'(k);
    endfunction

    function automatic logic [NWORDS*32-1:0] make_rec(input int id);
        logic [NWORDS*32-1:0] r;
        for (int k = 0; k < NWORDS; k++) r[32*k +: 32] = word_of(id, k);
        return r;
    endfunction

    task automatic push_exp(input int id, input logic [31:0] rdw_val);
        exp_t e;
        for (int k = 0; k < NWORDS; k++) begin
            e.data = (k == RDW) ? rdw_val : word_of(id, k);
            e.last = (k == NWORDS - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a record and hold it until the DUT accepts it (bounded).
    task automatic do_alloc(input logic [4:0] tag, input logic dn, input int id);
        logic acc;
        acc        = 1'b0;
        alloc_val  = 1'b1;
        alloc_tag  = tag;
        alloc_done = dn;
        alloc_rec  = make_rec(id);
        for (int c = 0; c < 300 && !acc; c++) begin
            acc = alloc_rdy;
            @(posedge clk);
            #1;
        end
        alloc_val = 1'b0;
        chk("alloc_accept", 32'(acc), 32'd1);
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [31:0] res);
        wb_val = 1'b1;
        wb_rd  = rd;
        wb_res = res;
        step(1);
        wb_val = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        logic ok;
        ok = (count == 3'd0) && !out_val && (sb_q.size() == 0);
        for (int c = 0; c < 600 && !ok; c++) begin
            step(1);
            ok = (count == 3'd0) && !out_val && (sb_q.size() == 0);
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Monitor: checks each transfer against the scoreboard, stall stability and idle zeros.
    initial begin
        logic        hold;
        logic [31:0] hold_data;
        logic        hold_last;
        exp_t        e;
        hold = 1'b0;
        hold_data = 32'd0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                hold = 1'b0;
            end else if (out_val) begin
                if (hold) begin
                    chk("stall_data", out_data, hold_data);
                    chk("stall_last", 32'(out_last), 32'(hold_last));
                end
                if (out_rdy) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%08h expected no word", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        chk("word_data", out_data, e.data);
                        chk("word_last", 32'(out_last), 32'(e.last));
                    end
                    hold = 1'b0;
                end else begin
                    hold      = 1'b1;
                    hold_data = out_data;
                    hold_last = out_last;
                end
            end else begin
                chk("idle_data_zero", out_data, 32'd0);
                hold = 1'b0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        arst_n = 1'b0; alloc_val = 1'b0; alloc_tag = 5'd0; alloc_done = 1'b0;
        alloc_rec = '0; wb_val = 1'b0; wb_rd = 5'd0; wb_res = 32'd0;
        ewb_val = 1'b0; ewb_rd = 5'd0; ewb_res = 32'd0; out_rdy = 1'b1;

        // Reset state
        step(3);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alloc_rdy", 32'(alloc_rdy), 32'd1);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(err_nomatch), 32'd0);
        arst_n = 1'b1;
        step(2);

        // Single record completed by wb; two-cycle latency to out_val
        do_alloc(5'd5, 1'b0, 1);
        push_exp(1, 32'hDEAD_BEEF);
        chk("t1_count_one", 32'(count), 32'd1);
        wb_val = 1'b1; wb_rd = 5'd5; wb_res = 32'hDEAD_BEEF;
        step(1);
        wb_val = 1'b0;
        chk("t1_lat_early", 32'(out_val), 32'd0);
        step(1);
        chk("t1_lat_rise", 32'(out_val), 32'd1);
        chk("t1_count_while_send", 32'(count), 32'd1);
        wait_drain("t1_drain");

        // Incomplete head blocks a complete younger entry
        do_alloc(5'd3, 1'b0, 2);
        push_exp(2, 32'h3333_3333);
        do_alloc(5'd4, 1'b1, 3);
        push_exp(3, word_of(3, RDW));
        step(6);
        chk("t2_blocked", 32'(out_val), 32'd0);
        chk("t2_count_two", 32'(count), 32'd2);
        do_wb(5'd3, 32'h3333_3333);
        wait_drain("t2_drain");

        // Full queue backpressure; fifth accepted only after first pop
        for (int i = 0; i < 4; i++) begin
            do_alloc(5'(10 + i), 1'b0, 10 + i);
            push_exp(10 + i, 32'hA000_0000 + 32'(i));
        end
        chk("t3_full_count", 32'(count), 32'd4);
        chk("t3_full_rdy", 32'(alloc_rdy), 32'd0);
        alloc_val = 1'b1; alloc_tag = 5'd14; alloc_done = 1'b0; alloc_rec = make_rec(14);
        step(3);
        chk("t3_hold_count", 32'(count), 32'd4);
        do_wb(5'd10, 32'hA000_0000);
        do_alloc(5'd14, 1'b0, 14);
        chk("t3_fifth_after_pop", 32'(sb_q.size()), 32'd39);
        chk("t3_count_after_fifth", 32'(count), 32'd4);
        push_exp(14, 32'hA000_0004);
        do_wb(5'd11, 32'hA000_0001);
        do_wb(5'd12, 32'hA000_0002);
        do_wb(5'd13, 32'hA000_0003);
        do_wb(5'd14, 32'hA000_0004);
        wait_drain("t3_drain");

        // Same-tag entries with simultaneous wb and ewb
        do_alloc(5'd7, 1'b0, 20);
        push_exp(20, 32'd1);
        do_alloc(5'd7, 1'b0, 21);
        push_exp(21, 32'd2);
        wb_val = 1'b1; wb_rd = 5'd7; wb_res = 32'd1;
        ewb_val = 1'b1; ewb_rd = 5'd7; ewb_res = 32'd2;
        step(1);
        wb_val = 1'b0; ewb_val = 1'b0;
        wait_drain("t4_drain");

        // x0 writeback forces zero; unmatched writeback sets sticky error
        do_alloc(5'd0, 1'b0, 30);
        push_exp(30, 32'd0);
        do_wb(5'd0, 32'h0000_1234);
        wait_drain("t5_drain");
        chk("t5_err_before", 32'(err_nomatch), 32'd0);
        do_wb(5'd9, 32'h0000_5555);
        chk("t5_err_set", 32'(err_nomatch), 32'd1);
        step(5);
        chk("t5_err_sticky", 32'(err_nomatch), 32'd1);

        // Stalls during SEND, then reset mid-record
        do_alloc(5'd2, 1'b1, 40);
        push_exp(40, word_of(40, RDW));
        for (int c = 0; c < 14; c++) begin
            out_rdy = pat[c % 4];
            step(1);
        end
        chk("t6_in_send", 32'(out_val), 32'd1);
        chk("t6_words_pending", 32'(sb_q.size() != 0), 32'd1);
        arst_n = 1'b0;
        sb_q.delete();
        out_rdy = 1'b1;
        #1;
        chk("t6_rst_out_val", 32'(out_val), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        step(1);
        chk("t6_rst_out_val_edge", 32'(out_val), 32'd0);
        chk("t6_rst_err", 32'(err_nomatch), 32'd0);
        chk("t6_rst_rdy", 32'(alloc_rdy), 32'd1);
        step(1);
        arst_n = 1'b1;
        step(5);
        chk("t6_no_resume", 32'(out_val), 32'd0);

        // Normal operation after reset
        do_alloc(5'd6, 1'b1, 50);
        push_exp(50, word_of(50, RDW));
        wait_drain("t7_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
